// File: rtl/clk_gate_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : clk_gate_ctrl                                              |
// | Description : Registered enable for a latch-based clock gate. Merges     |
// |               client activity requests, wakes the gate, flags when the   |
// |               gated clock is usable, holds it open for an idle window    |
// |               and counts wake-ups (saturating).                          |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module clk_gate_ctrl #(
  parameter int NUM_REQ  = 2,
  parameter int WAKE_CYC = 1,
  parameter int IDLE_CYC = 4,
  parameter int CNT_W    = 8
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [NUM_REQ-1:0] ACT_REQ,
  input  logic               TEST_EN,
  output logic               CLK_EN,
  output logic               GCLK_RDY,
  output logic [CNT_W-1:0]   WAKE_CNT
);

  localparam int MAX_A = (WAKE_CYC > IDLE_CYC) ? WAKE_CYC : IDLE_CYC;
  localparam int MAX_T = (MAX_A > 2) ? MAX_A : 2;
  localparam int TMR_W = $clog2(MAX_T);

  // Reload values; the idle reload is unused when IDLE_CYC is zero.
  localparam logic [TMR_W-1:0] WAKE_LD = TMR_W'(WAKE_CYC - 1);
  localparam logic [TMR_W-1:0] IDLE_LD = (IDLE_CYC > 0) ? TMR_W'(IDLE_CYC - 1) : '0;

  typedef enum logic [1:0] {
    S_OFF  = 2'd0,
    S_WAKE = 2'd1,
    S_ON   = 2'd2,
    S_HOLD = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [TMR_W-1:0]   timer_q, timer_d;
  logic               en_q, en_d;
  logic               rdy_q, rdy_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               cnt_inc;
  logic               any_req;

  assign any_req = |ACT_REQ;

  // Next-state logic: wake sequencing, idle hold and request merging.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    cnt_inc = 1'b0;
    case (state_q)
      S_OFF: begin
        if (any_req) begin
          state_d = S_WAKE;
          timer_d = WAKE_LD;
          cnt_inc = 1'b1;
        end
      end
      S_WAKE: begin
        // Wake always completes, even if requests drop meanwhile.
        if (timer_q == '0) begin
          state_d = S_ON;
        end else begin
          timer_d = timer_q - TMR_W'(1);
        end
      end
      S_ON: begin
        if (!any_req) begin
          if (IDLE_CYC == 0) begin
            state_d = S_OFF;
          end else begin
            state_d = S_HOLD;
            timer_d = IDLE_LD;
          end
        end
      end
      S_HOLD: begin
        // A request arriving on the expiry cycle keeps the gate open.
        if (any_req) begin
          state_d = S_ON;
        end else if (timer_q == '0) begin
          state_d = S_OFF;
        end else begin
          timer_d = timer_q - TMR_W'(1);
        end
      end
      default: begin
        state_d = S_OFF;
      end
    endcase
  end

  // Output and counter next values derived from the next state so they register cleanly.
  always_comb begin
    en_d  = (state_d != S_OFF);
    rdy_d = (state_d == S_ON) || (state_d == S_HOLD);
    cnt_d = cnt_q;
    if (cnt_inc && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // State, timer, enable, ready and counter registers with async reset.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= S_OFF;
      timer_q <= '0;
      en_q    <= 1'b0;
      rdy_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      en_q    <= en_d;
      rdy_q   <= rdy_d;
      cnt_q   <= cnt_d;
    end
  end

  // Only the DFT override is combinational; the functional term is a flop.
  assign CLK_EN   = en_q | TEST_EN;
  assign GCLK_RDY = rdy_q;
  assign WAKE_CNT = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_clk_gate_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_clk_gate_ctrl                                           |
// | Description : Scoreboard bench for clk_gate_ctrl with three parameter    |
// |               sets (default, 2-bit counter, slow wake / zero idle).      |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_clk_gate_ctrl;

  typedef struct {
    bit en;
    bit rdy;
    int age;
    int idle;
    int cnt;
  } mdl_t;

  typedef struct {
    int id;
    bit en;
    bit rdy;
    int cnt;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [1:0] req = 2'b00;
  logic [2:0] req_c = 3'b000;
  logic       test_en = 1'b0;
  bit         c_indep = 1'b0;

  logic       clk_en_a, rdy_a;
  logic [7:0] cnt_a;
  logic       clk_en_b, rdy_b;
  logic [1:0] cnt_b;
  logic       clk_en_c, rdy_c;
  logic [7:0] cnt_c;

  int n_cmp = 0;
  int n_err = 0;

  mdl_t ma, mb, mc;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  clk_gate_ctrl #(.NUM_REQ(2), .WAKE_CYC(1), .IDLE_CYC(4), .CNT_W(8)) u_a (
    .CLK(clk), .RST(rst), .ACT_REQ(req), .TEST_EN(test_en),
    .CLK_EN(clk_en_a), .GCLK_RDY(rdy_a), .WAKE_CNT(cnt_a));

  clk_gate_ctrl #(.NUM_REQ(2), .WAKE_CYC(1), .IDLE_CYC(4), .CNT_W(2)) u_b (
    .CLK(clk), .RST(rst), .ACT_REQ(req), .TEST_EN(test_en),
    .CLK_EN(clk_en_b), .GCLK_RDY(rdy_b), .WAKE_CNT(cnt_b));

  clk_gate_ctrl #(.NUM_REQ(3), .WAKE_CYC(3), .IDLE_CYC(0), .CNT_W(8)) u_c (
    .CLK(clk), .RST(rst), .ACT_REQ(req_c), .TEST_EN(test_en),
    .CLK_EN(clk_en_c), .GCLK_RDY(rdy_c), .WAKE_CNT(cnt_c));

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic mdl_t mdl_reset();
    mdl_t m;
    m.en = 1'b0; m.rdy = 1'b0; m.age = 0; m.idle = 0; m.cnt = 0;
    return m;
  endfunction

  // Behavioural model: age counts cycles since wake, idle counts request-free cycles while ready.
  function automatic mdl_t step(mdl_t m, bit r, bit rs, int wk, int idl, int cmax);
    mdl_t n = m;
    if (!rs) return mdl_reset();
    if (!m.en) begin
      if (r) begin
        n.en = 1'b1; n.rdy = 1'b0; n.age = 1;
        if (m.cnt < cmax) n.cnt = m.cnt + 1;
      end
    end else if (!m.rdy) begin
      if (m.age == wk) begin
        n.rdy = 1'b1; n.idle = 0;
      end else begin
        n.age = m.age + 1;
      end
    end else begin
      n.idle = r ? 0 : m.idle + 1;
      if (n.idle > idl) begin
        n.en = 1'b0; n.rdy = 1'b0;
      end
    end
    return n;
  endfunction

  task automatic compare_one(input exp_t e);
    bit         ce;
    bit         ry;
    logic [31:0] cn;
    string      nm;
    case (e.id)
      0: begin ce = clk_en_a; ry = rdy_a; cn = 32'(cnt_a); nm = "a"; end
      1: begin ce = clk_en_b; ry = rdy_b; cn = 32'(cnt_b); nm = "b"; end
      default: begin ce = clk_en_c; ry = rdy_c; cn = 32'(cnt_c); nm = "c"; end
    endcase
    check_val({nm, ".clk_en"}, 32'(ce), 32'(e.en | test_en));
    check_val({nm, ".rdy"},    32'(ry), 32'(e.rdy));
    check_val({nm, ".cnt"},    cn,      32'(e.cnt));
  endtask

  // One reference-clock cycle: model advances at the edge, DUT checked on the falling edge.
  task automatic tick();
    exp_t e;
    if (!c_indep) req_c = {1'b0, req};
    @(posedge clk);
    ma = step(ma, |req,   rst, 1, 4, 255);
    mb = step(mb, |req,   rst, 1, 4, 3);
    mc = step(mc, |req_c, rst, 3, 0, 255);
    exp_q.push_back('{0, ma.en, ma.rdy, ma.cnt});
    exp_q.push_back('{1, mb.en, mb.rdy, mb.cnt});
    exp_q.push_back('{2, mc.en, mc.rdy, mc.cnt});
    @(negedge clk);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      compare_one(e);
    end
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    int sat_exp[5];
    sat_exp = '{1, 2, 3, 3, 3};
    ma = mdl_reset(); mb = mdl_reset(); mc = mdl_reset();

    // Power-on reset
    #1;
    check_val("por.clk_en", 32'(clk_en_a), 32'd0);
    check_val("por.cnt", 32'(cnt_a), 32'd0);
    ticks(2);
    @(negedge clk);
    rst = 1'b1;

    // Wake latency
    ticks(3);
    req = 2'b01;
    tick();
    check_val("wake.en_first_edge", 32'(clk_en_a), 32'd1);
    check_val("wake.rdy_first_edge", 32'(rdy_a), 32'd0);
    tick();
    check_val("wake.rdy_second_edge", 32'(rdy_a), 32'd1);
    check_val("wake.cnt", 32'(cnt_a), 32'd1);

    // Idle hold: four cycles open after the last request, then closed
    ticks(2);
    req = 2'b00;
    for (int i = 0; i < 4; i++) begin
      tick();
      check_val("hold.en_open", 32'(clk_en_a), 32'd1);
    end
    tick();
    check_val("hold.en_closed", 32'(clk_en_a), 32'd0);
    check_val("hold.rdy_closed", 32'(rdy_a), 32'd0);

    // Re-request on the expiry edge keeps the gate open
    ticks(2);
    req = 2'b10;
    ticks(3);
    req = 2'b00;
    ticks(4);
    req = 2'b10;
    tick();
    check_val("rereq.en", 32'(clk_en_a), 32'd1);
    check_val("rereq.rdy", 32'(rdy_a), 32'd1);
    check_val("rereq.cnt", 32'(cnt_a), 32'd2);
    req = 2'b00;
    ticks(7);

    // DFT override in OFF
    test_en = 1'b1;
    #1;
    check_val("dft.en_comb", 32'(clk_en_a), 32'd1);
    check_val("dft.rdy", 32'(rdy_a), 32'd0);
    ticks(3);
    @(negedge clk);
    test_en = 1'b0;
    #1;
    check_val("dft.en_release", 32'(clk_en_a), 32'd0);

    // Asynchronous reset in HOLD
    req = 2'b01;
    ticks(3);
    req = 2'b00;
    ticks(2);
    #2;
    rst = 1'b0;
    #1;
    check_val("rst.clk_en", 32'(clk_en_a), 32'd0);
    check_val("rst.rdy", 32'(rdy_a), 32'd0);
    check_val("rst.cnt", 32'(cnt_a), 32'd0);
    ma = mdl_reset(); mb = mdl_reset(); mc = mdl_reset();
    ticks(2);
    rst = 1'b1;
    ticks(4);
    check_val("rst.stays_off", 32'(clk_en_a), 32'd0);

    // Saturating counter on the 2-bit instance
    for (int k = 0; k < 5; k++) begin
      req = 2'b01;
      tick();
      check_val("sat.cnt", 32'(cnt_b), 32'(sat_exp[k]));
      req = 2'b00;
      ticks(8);
    end

    // Random traffic on all instances
    c_indep = 1'b1;
    for (int i = 0; i < 300; i++) begin
      req     = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00;
      req_c   = ($urandom_range(0, 2) == 0) ? 3'($urandom) : 3'b000;
      test_en = ($urandom_range(0, 7) == 0);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
